// File: rtl/decoder_scan_n_if.sv
// Bundle of control inputs and decoded outputs for decoder_scan_n.
// The master drives enable/mode/select/divisor; the slave returns the
// registered one-hot lines, their index and the scan wrap pulse.
interface decoder_scan_n_if #(
  parameter int SEL_W = 3,
  parameter int DIV_W = 8
);
  localparam int N = 1 << SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [DIV_W-1:0] div;
  logic [N-1:0]     d;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (
    output en, mode, sel, div,
    input  d, idx, wrap
  );

  modport slave (
    input  en, mode, sel, div,
    output d, idx, wrap
  );
endinterface

// File: rtl/decoder_scan_n.sv
// Registered SEL_W -> 2**SEL_W one-hot decoder with selectable polarity.
// DIRECT mode decodes the select input; SCAN mode steps the active line
// from a prescaled counter with a runtime divisor (period = div+1 clocks).
// All outputs are flops updated on the same edge, so d always matches idx.
module decoder_scan_n #(
  parameter int SEL_W      = 3,
  parameter int DIV_W      = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  decoder_scan_n_if.slave bus
);

  localparam int N = 1 << SEL_W;

  // Level every line sits at when not selected; XOR with it sets polarity.
  localparam logic [N-1:0] INACTIVE = {N{ACTIVE_LOW}};

  // Operating state is not stored: it is decoded fresh every cycle.
  typedef enum logic [1:0] {
    OP_OFF,
    OP_DIRECT,
    OP_SCAN
  } op_e;

  op_e              op;
  logic [N-1:0]     d_q,     d_d;
  logic [SEL_W-1:0] idx_q,   idx_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             wrap_q,  wrap_d;

  // One-hot line pattern for a given index, already in output polarity.
  function automatic logic [N-1:0] drive_lines(input logic [SEL_W-1:0] i);
    logic [N-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return oh ^ INACTIVE;
  endfunction

  // Decode the operating state from enable and mode.
  always_comb begin
    op = OP_OFF;
    if (bus.en) begin
      op = bus.mode ? OP_SCAN : OP_DIRECT;
    end
  end

  // Next-state logic for index, prescaler, lines and wrap pulse.
  // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx_d   = idx_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    d_d     = INACTIVE;
    unique case (op)
      OP_DIRECT: begin
        // Direct load also clears the prescaler, so a later switch to
        // SCAN waits a full div+1 period before its first step.
        idx_d   = bus.sel;
        presc_d = '0;
        d_d     = drive_lines(bus.sel);
      end
      OP_SCAN: begin
        // '>=' rather than '==' so that lowering div below the current
        // count steps on the next edge instead of waiting for a wrap.
        if (presc_q >= bus.div) begin
          presc_d = '0;
          idx_d   = idx_q + SEL_W'(1);
          wrap_d  = &idx_q;
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
        d_d = drive_lines(idx_d);
      end
      OP_OFF: begin
        // Lines go inactive; index and prescaler hold for resume.
      end
      default: begin
      end
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q     <= INACTIVE;
      idx_q   <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      d_q     <= d_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.d    = d_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Self-checking bench for decoder_scan_n. Two builds share one stimulus:
// an 8-line active-high decoder and a 2-line active-low decoder.
module tb_decoder_scan_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic [2:0] sel;
  logic [7:0] div;

  int n_checks = 0;
  int n_fail   = 0;

  decoder_scan_n_if #(.SEL_W(3), .DIV_W(8)) bus0 ();
  decoder_scan_n_if #(.SEL_W(1), .DIV_W(8)) bus1 ();

  assign bus0.en   = en;
  assign bus0.mode = mode;
  assign bus0.sel  = sel;
  assign bus0.div  = div;
  assign bus1.en   = en;
  assign bus1.mode = mode;
  assign bus1.sel  = sel[0];
  assign bus1.div  = div;

  decoder_scan_n #(.SEL_W(3), .DIV_W(8), .ACTIVE_LOW(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  decoder_scan_n #(.SEL_W(1), .DIV_W(8), .ACTIVE_LOW(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  // Reference model: line number as a plain integer mod N, cycles counted
  // since the last step, and whether any line is driven at all.
  int NN[2]      = '{8, 2};
  int m_idx[2];
  int m_presc[2];
  bit m_wrap[2];
  bit m_act[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k]   = 0;
      m_presc[k] = 0;
      m_wrap[k]  = 1'b0;
      m_act[k]   = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 1'b0;
      if (!en) begin
        m_act[k] = 1'b0;
      end else if (!mode) begin
        m_act[k]   = 1'b1;
        m_idx[k]   = (k == 0) ? int'(sel) : int'(sel[0]);
        m_presc[k] = 0;
      end else begin
        m_act[k] = 1'b1;
        if (m_presc[k] >= int'(div)) begin
          m_presc[k] = 0;
          m_wrap[k]  = (m_idx[k] == NN[k] - 1);
          m_idx[k]   = (m_idx[k] + 1) % NN[k];
        end else begin
          m_presc[k] = m_presc[k] + 1;
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_d(input int k);
    int v;
    v = m_act[k] ? (1 << m_idx[k]) : 0;
    if (k == 1) v = ~v & 3;
    return 32'(v);
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".d0"},    32'(bus0.d),    exp_d(0));
    check({tag, ".idx0"},  32'(bus0.idx),  32'(m_idx[0]));
    check({tag, ".wrap0"}, 32'(bus0.wrap), 32'(m_wrap[0]));
    check({tag, ".d1"},    32'(bus1.d),    exp_d(1));
    check({tag, ".idx1"},  32'(bus1.idx),  32'(m_idx[1]));
    check({tag, ".wrap1"}, 32'(bus1.wrap), 32'(m_wrap[1]));
  endtask

  // One clock: model advances on the edge, outputs compared mid-low-phase.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int wraps;
    rst  = 1'b1;
    en   = 1'b0;
    mode = 1'b0;
    sel  = '0;
    div  = '0;
    model_reset();
    #1;
    // Reset state with no clock edge yet
    check("rst.d0", 32'(bus0.d), 32'h00);
    check("rst.d1_al", 32'(bus1.d), 32'h3);
    check_all("rst");
    @(negedge clk);
    rst = 1'b0;

    // DIRECT decode of every select value, then disable
    en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      cycle("direct");
      check("direct.onehot", 32'(bus0.d), 32'(1) << s);
    end
    en = 1'b0;
    cycle("off");
    check("off.d0", 32'(bus0.d), 32'h00);

    // SCAN div=2 from idx 0: one step every 3 clocks, a single wrap
    en   = 1'b1;
    sel  = 3'd0;
    cycle("scan3.load");
    mode = 1'b1;
    div  = 8'd2;
    wraps = 0;
    for (int c = 0; c < 26; c++) begin
      cycle("scan3");
      if (bus0.wrap === 1'b1) wraps++;
    end
    check("scan3.wraps", 32'(wraps), 32'd1);
    check("scan3.idx", 32'(bus0.idx), 32'd0);

    // SCAN div=0, freeze at idx 5 for 5 clocks, resume to 6
    div = 8'd0;
    for (int c = 0; c < 16 && m_idx[0] != 5; c++) cycle("scan1");
    check("scan1.at5", 32'(bus0.idx), 32'd5);
    en = 1'b0;
    for (int c = 0; c < 5; c++) cycle("freeze");
    check("freeze.idx", 32'(bus0.idx), 32'd5);
    check("freeze.d", 32'(bus0.d), 32'h00);
    en = 1'b1;
    cycle("resume");
    check("resume.idx", 32'(bus0.idx), 32'd6);

    // Divisor drop mid-count: step on the next edge, then period 11
    mode = 1'b0;
    sel  = 3'd0;
    cycle("div.load");
    mode = 1'b1;
    div  = 8'd200;
    for (int c = 0; c < 150; c++) cycle("div200");
    check("div200.idx", 32'(bus0.idx), 32'd0);
    div = 8'd10;
    cycle("div.drop");
    check("div.drop.idx", 32'(bus0.idx), 32'd1);
    for (int c = 0; c < 10; c++) cycle("div11");
    check("div11.hold", 32'(bus0.idx), 32'd1);
    cycle("div11");
    check("div11.step", 32'(bus0.idx), 32'd2);

    // Reset mid-scan at idx 4, then DIRECT load of sel=3
    div = 8'd0;
    for (int c = 0; c < 16 && m_idx[0] != 4; c++) cycle("scan4");
    check("scan4.at4", 32'(bus0.idx), 32'd4);
    async_reset("midrst");
    check("midrst.idx", 32'(bus0.idx), 32'd0);
    check("midrst.d", 32'(bus0.d), 32'h00);
    mode = 1'b0;
    sel  = 3'd3;
    cycle("sel3");
    check("sel3.d", 32'(bus0.d), 32'h08);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r == 0) async_reset("rnd.rst");
      en = (r >= 12);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) begin
        div = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                          : 8'($urandom_range(0, 5));
      end
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
